cloud_field_scroller: RTL and testbench

Parametrised background-motion engine that animates `N_CLOUDS` independent cloud sprites, one update per `frame_clk` (vertical sync). Each cloud scrolls left at its own parallax rate, wraps to the right edge when it leaves the screen, and is re-placed at a pseudo-random height. Positions feed the colour mapper's sprite-hit logic; `wrap_pulse` feeds scoring and sound.

---
 rtl/cloud_field_scroller_pkg.sv | 17 +
 rtl/cloud_field_scroller_channel.sv | 49 ++++
 rtl/cloud_field_scroller.sv | 65 ++++++
 tb/tb_cloud_field_scroller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cloud_field_scroller_pkg.sv
// cloud_pkg: keycodes, LFSR seed and bit-twiddling helpers shared by the cloud field.
package cloud_pkg;
    localparam logic [7:0] KEY_BOOST = 8'h07;
    localparam logic [7:0] KEY_FREEZE = 8'h29;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci form, taps 16,14,13,11 mapped onto a right-shifting register
    function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] v, input logic [3:0] n);
        logic [31:0] d;
        d = {v, v} << n;
        return d[31:16];
    endfunction
endpackage

// File: rtl/cloud_field_scroller_channel.sv
// cloud_channel: one cloud sprite with its own parallax divider, X/Y position and wrap pulse.
module cloud_channel
    import cloud_pkg::*;
#(
    parameter int INDEX = 0,
    parameter int PERIOD = 1,
    parameter int W = 10,
    parameter int X_MAX = 639,
    parameter int X_SPACING = 160,
    parameter int Y_MIN = 20,
    parameter int Y_RANGE_LOG2 = 7
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic                    run,
    input  logic [1:0]              step,
    input  logic [Y_RANGE_LOG2-1:0] rot_bits,
    output logic [W-1:0]            x,
    output logic [W-1:0]            y,
    output logic                    wrap
);
    localparam logic [2:0] LAST = 3'(PERIOD - 1);
    localparam logic [W-1:0] X_RST = W'(X_MAX - INDEX * X_SPACING);
    localparam logic [W-1:0] Y_RST = W'(Y_MIN + ((INDEX * 37) % (2 ** Y_RANGE_LOG2)));

    logic [2:0] cnt;
    logic move;

    always_comb move = run && cnt == LAST;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
            x <= X_RST;
            y <= Y_RST;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (run) cnt <= move ? 3'd0 : cnt + 3'd1;
            if (move && x < W'(step)) begin
                x <= W'(X_MAX);
                y <= W'(Y_MIN) + W'(rot_bits);
                wrap <= 1'b1;
            end else if (move) begin
                x <= x - W'(step);
            end
        end
    end
endmodule

// File: rtl/cloud_field_scroller.sv
// cloud_field_scroller: per-frame parallax scroller for N_CLOUDS cloud sprites with LFSR re-placement.
module cloud_field_scroller
    import cloud_pkg::*;
#(
    parameter int N_CLOUDS = 4,
    parameter int W = 10,
    parameter int X_MAX = 639,
    parameter int X_SPACING = 160,
    parameter int Y_MIN = 20,
    parameter int Y_RANGE_LOG2 = 7,
    parameter int CLOUD_SIZE = 100
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic                  enable,
    input  logic [7:0]            keycode,
    output logic [N_CLOUDS*W-1:0] CloudX,
    output logic [N_CLOUDS*W-1:0] CloudY,
    output logic [W-1:0]          CloudS,
    output logic [N_CLOUDS-1:0]   wrap_pulse
);
    logic [15:0] lfsr;
    logic run;
    logic [1:0] step;

    if (Y_MIN + 2 ** Y_RANGE_LOG2 - 1 >= 2 ** W) begin : g_bad_band
        $error("cloud band does not fit in W-bit coordinates");
    end

    // free-running: keeps re-placement heights varied even while frozen
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) lfsr <= LFSR_SEED;
        else lfsr <= lfsr16_next(lfsr);
    end

    always_comb begin
        run = enable && keycode != KEY_FREEZE;
        step = keycode == KEY_BOOST ? 2'd2 : 2'd1;
    end

    assign CloudS = W'(CLOUD_SIZE);

    for (genvar i = 0; i < N_CLOUDS; i++) begin : g_ch
        logic [Y_RANGE_LOG2-1:0] rot_bits;
        assign rot_bits = Y_RANGE_LOG2'(rotl16(lfsr, 4'((3 * i) % 16)));
        cloud_channel #(
            .INDEX(i),
            .PERIOD(i + 1),
            .W(W),
            .X_MAX(X_MAX),
            .X_SPACING(X_SPACING),
            .Y_MIN(Y_MIN),
            .Y_RANGE_LOG2(Y_RANGE_LOG2)
        ) u_ch (
            .frame_clk(frame_clk),
            .Reset(Reset),
            .run(run),
            .step(step),
            .rot_bits(rot_bits),
            .x(CloudX[i*W +: W]),
            .y(CloudY[i*W +: W]),
            .wrap(wrap_pulse[i])
        );
    end
endmodule

// File: tb/tb_cloud_field_scroller.sv
// tb_cloud_field_scroller: directed stimulus with a frame-level reference model checked every frame.
module tb_cloud_field_scroller;
    localparam int N = 4;
    localparam int W = 10;

    logic frame_clk = 1'b0;
    logic Reset = 1'b1;
    logic enable = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [N*W-1:0] CloudX, CloudY;
    logic [W-1:0] CloudS;
    logic [N-1:0] wrap_pulse;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    int mx[N], my[N], mw[N], runs[N];
    int ml;

    cloud_field_scroller dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .enable(enable),
        .keycode(keycode),
        .CloudX(CloudX),
        .CloudY(CloudY),
        .CloudS(CloudS),
        .wrap_pulse(wrap_pulse)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic int gx(int i);
        return int'(CloudX[i*W +: W]);
    endfunction

    function automatic int gy(int i);
        return int'(CloudY[i*W +: W]);
    endfunction

    function automatic int lfsr_step(int l);
        int b;
        b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | (b << 15);
    endfunction

    function automatic int rot(int l, int r);
        r = r % 16;
        return ((l << r) | (l >> (16 - r))) & 16'hFFFF;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = 639 - i * 160;
            my[i] = 20 + (i * 37) % 128;
            mw[i] = 0;
            runs[i] = 0;
        end
        ml = 16'hACE1;
    endtask

    task automatic model_edge(bit en, logic [7:0] key);
        bit r;
        int st;
        r = en && key != 8'h29;
        st = key == 8'h07 ? 2 : 1;
        for (int i = 0; i < N; i++) begin
            mw[i] = 0;
            if (r) begin
                runs[i]++;
                if (runs[i] % (i + 1) == 0) begin
                    if (mx[i] < st) begin
                        mx[i] = 639;
                        my[i] = 20 + rot(ml, 3 * i) % 128;
                        mw[i] = 1;
                    end else mx[i] -= st;
                end
            end
        end
        ml = lfsr_step(ml);
    endtask

    task automatic frame(bit en, logic [7:0] key);
        enable = en;
        keycode = key;
        @(posedge frame_clk);
        model_edge(en, key);
        @(negedge frame_clk);
    endtask

    task automatic frames(int n, bit en, logic [7:0] key);
        for (int k = 0; k < n; k++) frame(en, key);
    endtask

    task automatic check_reset_literals();
        chk("rst_x0", gx(0), 639);
        chk("rst_x1", gx(1), 479);
        chk("rst_x2", gx(2), 319);
        chk("rst_x3", gx(3), 159);
        chk("rst_y0", gy(0), 20);
        chk("rst_y1", gy(1), 57);
        chk("rst_y2", gy(2), 94);
        chk("rst_y3", gy(3), 131);
        chk("rst_wrap", int'(wrap_pulse), 0);
        chk("rst_size", int'(CloudS), 100);
    endtask

    // asserted between edges; outputs must be at reset values before the next edge
    task automatic do_reset();
        @(posedge frame_clk);
        #2 Reset = 1'b1;
        model_reset();
        #1 check_reset_literals();
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    always @(negedge frame_clk) begin
        if (cmp_en) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("model_x%0d", i), gx(i), mx[i]);
                chk($sformatf("model_y%0d", i), gy(i), my[i]);
                chk($sformatf("model_wrap%0d", i), int'(wrap_pulse[i]), mw[i]);
            end
        end
    end

    initial begin
        chk("pin_lfsr", lfsr_step(16'hACE1), 16'h5670);
        chk("pin_rot", rot(16'h8001, 3), 16'h000C);
        model_reset();
        cmp_en = 1'b1;
        @(negedge frame_clk);
        check_reset_literals();
        Reset = 1'b0;

        frames(4, 1'b1, 8'h00);
        chk("par_x0", gx(0), 635);
        chk("par_x1", gx(1), 477);
        chk("par_x2", gx(2), 318);
        chk("par_x3", gx(3), 158);

        do_reset();
        frames(10, 1'b1, 8'h07);
        chk("boost_x0", gx(0), 619);
        chk("boost_x1", gx(1), 469);

        frames(20, 1'b1, 8'h29);
        chk("freeze_x0", gx(0), 619);
        chk("freeze_x1", gx(1), 469);
        frames(20, 1'b0, 8'h00);
        chk("hold_x0", gx(0), 619);
        chk("hold_x1", gx(1), 469);
        frames(2, 1'b1, 8'h00);
        chk("resume_x0", gx(0), 617);
        chk("resume_x1", gx(1), 468);

        do_reset();
        frames(636, 1'b1, 8'h00);
        chk("pre_wrap_x3", gx(3), 0);
        frames(3, 1'b1, 8'h00);
        chk("still_zero_x3", gx(3), 0);
        frame(1'b1, 8'h00);
        chk("wrap_x3", gx(3), 639);
        chk("wrap_pulse3", int'(wrap_pulse[3]), 1);
        chk("wrap_x0", gx(0), 639);
        chk("wrap_pulse0", int'(wrap_pulse[0]), 1);
        chk("wrap_y3_in_band", int'(gy(3) >= 20 && gy(3) <= 147), 1);
        frame(1'b1, 8'h00);
        chk("pulse_cleared", int'(wrap_pulse), 0);

        do_reset();
        frames(5, 1'b1, 8'h07);
        do_reset();
        frames(320, 1'b1, 8'h07);
        chk("boost_wrap_x0", gx(0), 639);
        chk("boost_wrap_pulse0", int'(wrap_pulse[0]), 1);
        frame(1'b1, 8'h07);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
